// File: rtl/acc_alu_sequencer.sv
// rtl/acc_alu_sequencer.sv - command sequencer for the accumulator / operand / add-sub bus datapath
// Define ACC_SEQ_BUS_GUARD_EN to insert a dead bus cycle (TURN) between operand load and execute.
module acc_alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_cf,
  output logic              rsp_zf,
  output logic              rsp_err,
  output logic              bus_drv_en,
  output logic [DATA_W-1:0] bus_drv_data,
  input  logic [DATA_W-1:0] bus_in,
  output logic              a_load,
  output logic              a_oe,
  output logic              b_load,
  output logic              alu_oe_n,
  output logic              alu_sub,
  input  logic              cf_in,
  input  logic              zf_in
);

  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_LDA, S_RDA, S_LDB, S_TURN, S_EXE, S_FLG, S_RSP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_cf;
  logic              r_rsp_zf;
  logic              r_rsp_err;
  logic [DATA_W-1:0] w_imm;
  logic              w_accept;
  logic              w_illegal;

  // CLR reuses the LDA path with a forced-zero immediate.
  assign w_imm     = (r_op == OP_CLR) ? '0 : r_data;
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_illegal = !(cmd_op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_CLR});

  assign rsp_data = r_rsp_data;
  assign rsp_cf   = r_rsp_cf;
  assign rsp_zf   = r_rsp_zf;
  assign rsp_err  = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    bus_drv_en   = 1'b0;
    bus_drv_data = '0;
    a_load       = 1'b0;
    a_oe         = 1'b0;
    b_load       = 1'b0;
    alu_oe_n     = 1'b1;
    alu_sub      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_LDA, OP_CLR: w_next = S_LDA;
            OP_OUT:         w_next = S_RDA;
            OP_ADD, OP_SUB: w_next = S_LDB;
            default:        w_next = S_RSP;
          endcase
        end
      end
      S_LDA: begin
        bus_drv_en   = 1'b1;
        bus_drv_data = w_imm;
        a_load       = 1'b1;
        w_next       = S_RSP;
      end
      S_RDA: begin
        a_oe   = 1'b1;
        w_next = S_RSP;
      end
      S_LDB: begin
        bus_drv_en   = 1'b1;
        bus_drv_data = r_data;
        b_load       = 1'b1;
`ifdef ACC_SEQ_BUS_GUARD_EN
        w_next       = S_TURN;
`else
        w_next       = S_EXE;
`endif
      end
      S_TURN: begin
        w_next = S_EXE;
      end
      S_EXE: begin
        alu_oe_n = 1'b0;
        alu_sub  = (r_op == OP_SUB);
        a_load   = 1'b1;
        w_next   = S_FLG;
      end
      S_FLG: begin
        w_next = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Response fields are cleared on accept so non-arithmetic ops report zero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_cf   <= 1'b0;
      r_rsp_zf   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_data     <= cmd_data;
        r_rsp_data <= '0;
        r_rsp_cf   <= 1'b0;
        r_rsp_zf   <= 1'b0;
        r_rsp_err  <= w_illegal;
      end
      case (r_state)
        S_LDA:        r_rsp_data <= w_imm;
        S_RDA, S_EXE: r_rsp_data <= bus_in;
        S_FLG: begin
          r_rsp_cf <= cf_in;
          r_rsp_zf <= zf_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_alu_sequencer.sv
// tb/tb_acc_alu_sequencer.sv - table-driven scoreboard bench for acc_alu_sequencer with a datapath model
module tb_acc_alu_sequencer;

  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;
`ifdef ACC_SEQ_BUS_GUARD_EN
  localparam int LAT_AS = 5;
`else
  localparam int LAT_AS = 4;
`endif

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] edata;
    logic       ecf;
    logic       ezf;
    logic       eerr;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       cf;
    logic       zf;
    logic       err;
    int         lat;
  } exp_t;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data, rsp_data, bus_drv_data, bus;
  logic       rsp_cf, rsp_zf, rsp_err, bus_drv_en;
  logic       a_load, a_oe, b_load, alu_oe_n, alu_sub;
  logic [7:0] m_a, m_b;
  logic       m_cf, m_zf;
  logic [8:0] alu_sum;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[18];

  acc_alu_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cf(rsp_cf), .rsp_zf(rsp_zf), .rsp_err(rsp_err),
    .bus_drv_en(bus_drv_en), .bus_drv_data(bus_drv_data), .bus_in(bus),
    .a_load(a_load), .a_oe(a_oe), .b_load(b_load),
    .alu_oe_n(alu_oe_n), .alu_sub(alu_sub),
    .cf_in(m_cf), .zf_in(m_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: A, B, add/sub with registered flags, shared bus
  always_comb begin
    alu_sum = alu_sub ? ({1'b0, m_a} + {1'b0, ~m_b} + 9'd1) : ({1'b0, m_a} + {1'b0, m_b});
    if (bus_drv_en)     bus = bus_drv_data;
    else if (a_oe)      bus = m_a;
    else if (!alu_oe_n) bus = alu_sum[7:0];
    else                bus = 8'h00;
  end

  always @(posedge clk) begin
    if (a_load) m_a <= bus;
    if (b_load) m_b <= bus;
    if (!alu_oe_n) begin
      m_cf <= alu_sum[8];
      m_zf <= (alu_sum[7:0] == 8'h00);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("bus_exclusive", ((int'(bus_drv_en) + int'(a_oe) + int'(!alu_oe_n)) <= 1), 1);
      check("load_exclusive", a_load && b_load, 0);
    end
  end

  function automatic vec_t mkv(logic [2:0] op, logic [7:0] d, logic [7:0] ed,
                               logic cf, logic zf, logic err, int lat);
    vec_t v;
    v.op = op; v.data = d; v.edata = ed; v.ecf = cf; v.ezf = zf; v.eerr = err; v.lat = lat;
    return v;
  endfunction

  task automatic do_cmd(input vec_t v, input int hold);
    exp_t e, got;
    int   n;
    logic act;
    e.data = v.edata; e.cf = v.ecf; e.zf = v.ezf; e.err = v.eerr; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'b110; cmd_data = ~v.data;
    n = 1;
    act = bus_drv_en | a_oe | a_load | b_load | !alu_oe_n | alu_sub;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
      act |= bus_drv_en | a_oe | a_load | b_load | !alu_oe_n | alu_sub;
    end
    got = sb.pop_front();
    check("rsp_latency", rsp_valid ? n : 99, got.lat);
    check("rsp_data", rsp_data, got.data);
    check("rsp_cf", rsp_cf, got.cf);
    check("rsp_zf", rsp_zf, got.zf);
    check("rsp_err", rsp_err, got.err);
    check("cmd_ready_in_rsp", cmd_ready, 0);
    if (got.err) check("illegal_ctl_idle", act, 0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_op = OP_LDA; cmd_data = 8'h99;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, got.data);
      check("hold_not_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0]  = mkv(OP_LDA, 8'h05, 8'h05, 0, 0, 0, 2);
    vecs[1]  = mkv(OP_ADD, 8'h03, 8'h08, 0, 0, 0, LAT_AS);
    vecs[2]  = mkv(OP_SUB, 8'h08, 8'h00, 1, 1, 0, LAT_AS);
    vecs[3]  = mkv(OP_OUT, 8'hAA, 8'h00, 0, 0, 0, 2);
    vecs[4]  = mkv(OP_LDA, 8'hFF, 8'hFF, 0, 0, 0, 2);
    vecs[5]  = mkv(OP_ADD, 8'h01, 8'h00, 1, 1, 0, LAT_AS);
    vecs[6]  = mkv(OP_LDA, 8'h10, 8'h10, 0, 0, 0, 2);
    vecs[7]  = mkv(OP_SUB, 8'h20, 8'hF0, 0, 0, 0, LAT_AS);
    vecs[8]  = mkv(OP_OUT, 8'h00, 8'hF0, 0, 0, 0, 2);
    vecs[9]  = mkv(OP_CLR, 8'h55, 8'h00, 0, 0, 0, 2);
    vecs[10] = mkv(OP_OUT, 8'h33, 8'h00, 0, 0, 0, 2);
    vecs[11] = mkv(3'b110, 8'h77, 8'h00, 0, 0, 1, 1);
    vecs[12] = mkv(3'b000, 8'h12, 8'h00, 0, 0, 1, 1);
    vecs[13] = mkv(3'b111, 8'hFE, 8'h00, 0, 0, 1, 1);
    vecs[14] = mkv(OP_LDA, 8'h3C, 8'h3C, 0, 0, 0, 2);
    vecs[15] = mkv(OP_ADD, 8'hC4, 8'h00, 1, 1, 0, LAT_AS);
    vecs[16] = mkv(OP_SUB, 8'h01, 8'hFF, 0, 0, 0, LAT_AS);
    vecs[17] = mkv(OP_ADD, 8'h01, 8'h00, 1, 1, 0, LAT_AS);

    m_a = 8'h00; m_b = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {bus_drv_en, a_load, a_oe, b_load, alu_sub, rsp_valid}, 6'b0);
    check("rst_alu_oe_n", alu_oe_n, 1);
    check("rst_rsp", {rsp_data, rsp_cf, rsp_zf, rsp_err}, 11'b0);
    check("rst_drv_data", bus_drv_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    for (int i = 0; i < 18; i++) begin
      do_cmd(vecs[i], 0);
      if (vecs[i].op == OP_OUT) check("out_keeps_a", m_a, vecs[i].edata);
    end

    // Held response: stable output, no new command taken while waiting
    do_cmd(mkv(OP_LDA, 8'h42, 8'h42, 0, 0, 0, 2), 5);
    check("held_cmd_ignored", m_a, 8'h42);
    do_cmd(mkv(OP_OUT, 8'h00, 8'h42, 0, 0, 0, 2), 0);

    // Reset in the middle of EXE drops the ALU driver and the command
    do_cmd(mkv(OP_LDA, 8'h20, 8'h20, 0, 0, 0, 2), 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = 8'h01;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (alu_oe_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reach_exe", alu_oe_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_alu_oe_n", alu_oe_n, 1);
    check("rst_mid_a_load", a_load, 0);
    check("rst_mid_rsp", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = mkv(OP_OUT, 8'h00, 8'h20, 0, 0, 0, 2);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("no_rsp_after_rst", n, 0);
    check("ready_after_rst", cmd_ready, 1);
    do_cmd(v, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
